wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
// - Architectural integer register file; sink of the write-back interface driven by the MEM/WB pipeline register.
// - Accepts one write per cycle and serves two read ports to the decode stage.
// - x0 is hardwired to zero.
// - Keeps a committed-write counter for performance and debug.
// PARAMETERS
// - DATA_W    32  register width; matches RegBus
// - ADDR_W    5   register index width; matches RegAddrBus
// - NUM_REGS  32  number of architectural registers; must equal 2**ADDR_W
// - CNT_W     32  width of the committed-write counter
// PORTS
// - clk       in   1       clock, rising edge
// - rst       in   1       reset, synchronous, active-high
// - wb_wreg   in   1       write-back write enable
// - wb_wd     in   ADDR_W  write-back destination index
// - wb_wdata  in   DATA_W  write-back data
// - re1       in   1       read port 1 enable
// - raddr1    in   ADDR_W  read port 1 index
// - rdata1    out  DATA_W  read port 1 data (combinational)
// - re2       in   1       read port 2 enable
// - raddr2    in   ADDR_W  read port 2 index
// - rdata2    out  DATA_W  read port 2 data (combinational)
// - wr_count  out  CNT_W   committed-write counter (registered)
// BEHAVIOUR
// - Reset is synchronous. While rst=1 at a rising edge:
//   - all NUM_REGS entries clear to 0;
//   - wr_count clears to 0;
//   - any write presented in that cycle is dropped.
// - While rst=1, rdata1 and rdata2 are forced to 0 combinationally.
// - Write: accepted at the rising edge when rst=0, wb_wreg=1 and wb_wd!=0.
//   - regs[wb_wd] <= wb_wdata; wr_count <= wr_count+1 at the same edge.
//   - Write to index 0 is discarded and does not count.
//   - wb_wreg=0 means no write, whatever wb_wd/wb_wdata hold. A bubble from a WB stall arrives as wreg=0, wd=0, data=0.
// - wr_count wraps from 2**CNT_W-1 to 0 without saturation; there is no overflow flag.
// - Read port n (n=1,2), priority order:
//   1. rst=1 -> 0
//   2. ren=0 -> 0
//   3. raddrn==0 -> 0
//   4. bypass hit (see CONFIGURATION) -> wb_wdata
//   5. otherwise -> regs[raddrn]
// - Read latency is 0 cycles (combinational). Write latency is 1 edge; the new value is visible from the array after the edge.
// - Both ports may read the same index in the same cycle, including the index being written; both return identical data.
// - No X propagation: every read path resolves to a defined value under every enable combination.
// CONFIGURATION
// - Macro WB_REGFILE_BYPASS_EN:
//   - Defined: read port n returns wb_wdata in the same cycle when wb_wreg=1, wb_wd==raddrn, wb_wd!=0, ren=1 and rst=0. This is write-before-read, which resolves the WB->ID hazard without a stall.
//   - Undefined: no bypass. Reads return the pre-edge array value, so the decode stage must handle the hazard. This costs one extra stall cycle on a WB->ID dependency.
//   - The macro does not affect write, reset or wr_count behaviour.
// TESTING
// - Reset clear: write 0xDEADBEEF to x5, then assert rst for 1 cycle -> next cycle re1=1, raddr1=5 gives rdata1=0, wr_count=0.
// - Basic write/read: write 0x12345678 to x7 -> next cycle raddr1=7 and raddr2=7 both give 0x12345678; wr_count=1.
// - x0 hardwired: wb_wreg=1, wb_wd=0, wb_wdata=0xFFFFFFFF -> raddr1=0 gives 0; wr_count unchanged.
// - Same-cycle hazard: x9 holds 0x1; write x9=0xA5A5A5A5 while raddr1=9, re1=1 ->
//   - bypass build: 0xA5A5A5A5 that cycle;
//   - non-bypass build: 0x1 that cycle, 0xA5A5A5A5 the next.
// - Enables and bubbles: re2=0, raddr2=3 with x3=0x55 -> rdata2=0. Bubble input (wreg=0, wd=0, data=0) for 10 cycles -> no register or wr_count change.
// - Counter wrap (CNT_W=4 build): perform 16 writes to x1 -> wr_count reaches 15, then reads 0 after the 16th; x1 holds the last data.

Source files
------------

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - write-back and decode read-port bundle for the register file
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              wb_wreg;
    logic [ADDR_W-1:0] wb_wd;
    logic [DATA_W-1:0] wb_wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic [CNT_W-1:0]  wr_count;

    modport master (
        output wb_wreg, wb_wd, wb_wdata, re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, wr_count
    );

    modport slave (
        input  wb_wreg, wb_wd, wb_wdata, re1, raddr1, re2, raddr2,
        output rdata1, rdata2, wr_count
    );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - architectural register file, x0 hardwired, committed-write counter; WB_REGFILE_BYPASS_EN enables WB->ID bypass
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
) (
    input logic          clk,
    input logic          rst,
    wb_regfile_if.slave  bus
);
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [CNT_W-1:0]  cnt_q;
    logic              wr_en;
    logic              hit1;
    logic              hit2;

    // A write commits only for a real destination; x0 writes and bubbles are dropped
    assign wr_en = bus.wb_wreg && (bus.wb_wd != '0);

`ifdef WB_REGFILE_BYPASS_EN
    // Same-cycle forwarding of the write-back value to a matching decode read
    always_comb begin
        hit1 = wr_en && (bus.wb_wd == bus.raddr1);
        hit2 = wr_en && (bus.wb_wd == bus.raddr2);
    end
`else
    // No forwarding: readers see the pre-edge array and decode stalls on the hazard
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
    end
`endif

    // Array update and committed-write counting; reset clears everything and drops the write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            cnt_q <= '0;
        end else if (wr_en) begin
            regs[bus.wb_wd] <= bus.wb_wdata;
            cnt_q           <= cnt_q + 1'b1;
        end
    end

    assign bus.wr_count = cnt_q;

    // Read port 1: reset, disable and x0 all yield zero before any array or bypass value
    always_comb begin
        bus.rdata1 = '0;
        if (!rst && bus.re1 && (bus.raddr1 != '0)) begin
            if (hit1) begin
                bus.rdata1 = bus.wb_wdata;
            end else begin
                bus.rdata1 = regs[bus.raddr1];
            end
        end
    end

    // Read port 2: same priority chain as port 1
    always_comb begin
        bus.rdata2 = '0;
        if (!rst && bus.re2 && (bus.raddr2 != '0)) begin
            if (hit2) begin
                bus.rdata2 = bus.wb_wdata;
            end else begin
                bus.rdata2 = regs[bus.raddr2];
            end
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile (4-bit counter build)
module tb_wb_regfile;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;
`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        int          id;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(32), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb_q [$];
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    int          n_checks = 0;
    int          n_errors = 0;
    int          step_id  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic r, input logic ren, input logic [4:0] a,
                                               input logic wreg, input logic [4:0] wd,
                                               input logic [31:0] wdata);
        if (r || !ren || a == 5'd0) return 32'h0;
        if (BYP && wreg && wd == a && wd != 5'd0) return wdata;
        return m_regs[a];
    endfunction

    // Drive one cycle, push the expected outputs, then advance the model across the edge
    task automatic cycle(input logic r, input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                         input logic ren1, input logic [4:0] a1, input logic ren2, input logic [4:0] a2);
        exp_t e;
        rst          = r;
        bus.wb_wreg  = wreg;
        bus.wb_wd    = wd;
        bus.wb_wdata = wdata;
        bus.re1      = ren1;
        bus.raddr1   = a1;
        bus.re2      = ren2;
        bus.raddr2   = a2;
        e.id  = step_id++;
        e.r1  = model_read(r, ren1, a1, wreg, wd, wdata);
        e.r2  = model_read(r, ren2, a2, wreg, wd, wdata);
        e.cnt = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_cnt = 32'h0;
        end else if (wreg && wd != 5'd0) begin
            m_regs[wd] = wdata;
            m_cnt = (m_cnt + 32'd1) % (32'd1 << CNT_W);
        end
    endtask

    // Outputs are compared mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check($sformatf("rdata1#%0d", e.id), bus.rdata1, e.r1);
            check($sformatf("rdata2#%0d", e.id), bus.rdata2, e.r2);
            check($sformatf("wr_count#%0d", e.id), {{(32-CNT_W){1'b0}}, bus.wr_count}, e.cnt);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.wb_wreg = 1'b0; bus.wb_wd = '0; bus.wb_wdata = '0;
        bus.re1 = 1'b0; bus.raddr1 = '0; bus.re2 = 1'b0; bus.raddr2 = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_cnt = 32'h0;
        @(posedge clk);
        #1;

        // Reset clear, including a write presented during reset
        cycle(0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 0, 5'd0);
        cycle(0, 0, 5'd0, 32'h0,        1, 5'd5, 1, 5'd5);
        cycle(1, 1, 5'd6, 32'h11111111, 1, 5'd5, 1, 5'd6);
        cycle(0, 0, 5'd0, 32'h0,        1, 5'd5, 1, 5'd6);

        // Basic write/read on both ports
        cycle(0, 1, 5'd7, 32'h12345678, 0, 5'd0, 0, 5'd0);
        cycle(0, 0, 5'd0, 32'h0,        1, 5'd7, 1, 5'd7);

        // x0 is hardwired and does not count
        cycle(0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 1, 5'd0);
        cycle(0, 0, 5'd0, 32'h0,        1, 5'd0, 1, 5'd7);

        // Same-cycle hazard on x9, both ports reading the index being written
        cycle(0, 1, 5'd9, 32'h00000001, 0, 5'd0, 0, 5'd0);
        cycle(0, 1, 5'd9, 32'hA5A5A5A5, 1, 5'd9, 1, 5'd9);
        cycle(0, 0, 5'd0, 32'h0,        1, 5'd9, 1, 5'd9);

        // Read enables gate the data
        cycle(0, 1, 5'd3, 32'h00000055, 0, 5'd0, 0, 5'd0);
        cycle(0, 0, 5'd0, 32'h0,        1, 5'd3, 0, 5'd3);
        cycle(0, 0, 5'd0, 32'h0,        0, 5'd3, 1, 5'd3);

        // Bubbles leave array and counter untouched
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 5'd0, 32'h0, 1, 5'(i * 3 + 1), 1, 5'(31 - i));
        end
        cycle(0, 0, 5'd7, 32'hCAFEF00D, 1, 5'd7, 1, 5'd9);

        // Counter wrap with the narrow counter
        cycle(1, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 5'd1, 32'h1000 + 32'(i), 1, 5'd1, 0, 5'd0);
        end
        cycle(0, 0, 5'd0, 32'h0, 1, 5'd1, 1, 5'd1);

        // Random mix of writes, reads, enables and occasional reset
        for (int i = 0; i < 60; i++) begin
            logic [4:0] wd, a1, a2;
            wd = 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? wd : 5'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 3) == 0) ? wd : 5'($urandom_range(0, 7));
            cycle(($urandom_range(0, 19) == 0), 1'($urandom), wd, $urandom,
                  ($urandom_range(0, 4) != 0), a1, ($urandom_range(0, 4) != 0), a2);
        end

        cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0);
        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
